// File: rtl/pin_entry_sequencer_if.sv
// Keypad / comparator bundle for pin_entry_sequencer.
// master: keypad + comparator side (drives keys and the verdict).
// slave : the sequencer (consumes keys, presents the PIN and status).
interface pin_entry_sequencer_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       unlocked;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [3:0] digit4;
  logic [2:0] entry_count;
  logic       access_granted;
  logic       access_denied;
  logic       locked_out;
  logic [3:0] fail_count;

  modport master (
    output key_valid, key_code, unlocked,
    input  digit1, digit2, digit3, digit4, entry_count,
    input  access_granted, access_denied, locked_out, fail_count
  );

  modport slave (
    input  key_valid, key_code, unlocked,
    output digit1, digit2, digit3, digit4, entry_count,
    output access_granted, access_denied, locked_out, fail_count
  );
endinterface

// File: rtl/pin_entry_sequencer.sv
// pin_entry_sequencer: keypad front end for the 4-digit lock comparator.
// Assembles a 4-digit PIN, presents it to the comparator only while in CHECK,
// samples the verdict, then grants access or counts a failure. Repeated
// failures trigger a timed lockout.
// Optional feature macro: PIN_ENTRY_TIMEOUT_EN (clears a partial entry after
// TIMEOUT_CYCLES idle cycles; without it a partial entry is held forever).
module pin_entry_sequencer #(
  parameter int unsigned RESULT_LATENCY = 1,
  parameter int unsigned GRANT_CYCLES   = 16,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input logic                  clk,
  input logic                  reset,
  pin_entry_sequencer_if.slave bus
);

  localparam int unsigned WAIT_W  = (RESULT_LATENCY < 1) ? 1 : $clog2(RESULT_LATENCY + 1);
  localparam int unsigned GRANT_W = (GRANT_CYCLES < 2) ? 1 : $clog2(GRANT_CYCLES + 1);
  localparam int unsigned LOCK_W  = (LOCKOUT_CYCLES < 2) ? 1 : $clog2(LOCKOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_CHECK   = 2'd1,
    ST_GRANTED = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  // Saturating increment of the 4-bit failure counter.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    logic [3:0] r;
    if (v == 4'hF) begin
      r = 4'hF;
    end else begin
      r = v + 4'd1;
    end
    return r;
  endfunction

  state_t              state_q, state_d;
  logic [3:0][3:0]     pin_q, pin_d;          // index 0 holds digit1
  logic [2:0]          entry_count_q, entry_count_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [GRANT_W-1:0]  grant_cnt_q, grant_cnt_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [3:0]          fail_count_q, fail_count_d;
  logic                access_granted_q, access_granted_d;
  logic                access_denied_q, access_denied_d;
  logic                locked_out_q, locked_out_d;
  logic [3:0][3:0]     digit_q, digit_d;
  logic                fail_event_s;
  logic [3:0]          fail_next_s;

`ifdef PIN_ENTRY_TIMEOUT_EN
  localparam int unsigned IDLE_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
`endif

  // Next-state, buffer, counters and registered-output values.
  always_comb begin
    state_d          = state_q;
    pin_d            = pin_q;
    entry_count_d    = entry_count_q;
    wait_cnt_d       = wait_cnt_q;
    grant_cnt_d      = grant_cnt_q;
    lock_cnt_d       = lock_cnt_q;
    fail_count_d     = fail_count_q;
    fail_event_s     = 1'b0;
    fail_next_s      = sat_inc4(fail_count_q);

    case (state_q)
      ST_ENTRY: begin
        if (bus.key_valid) begin
          if (bus.key_code <= 4'h9) begin
            // A full buffer ignores further digits; it never shifts.
            if (entry_count_q < 3'd4) begin
              pin_d[entry_count_q[1:0]] = bus.key_code;
              entry_count_d             = entry_count_q + 3'd1;
            end else begin
              entry_count_d = entry_count_q;
            end
          end else if (bus.key_code == 4'hA) begin
            pin_d         = {4{4'h0}};
            entry_count_d = 3'd0;
          end else if (bus.key_code == 4'hB) begin
            if (entry_count_q == 3'd4) begin
              state_d    = ST_CHECK;
              wait_cnt_d = '0;
            end else begin
              // Enter on a short entry counts as a wrong PIN.
              fail_event_s  = 1'b1;
              pin_d         = {4{4'h0}};
              entry_count_d = 3'd0;
            end
          end else begin
            state_d = ST_ENTRY;
          end
        end else begin
          state_d = ST_ENTRY;
        end
      end

      ST_CHECK: begin
        if (wait_cnt_q == WAIT_W'(RESULT_LATENCY)) begin
          pin_d         = {4{4'h0}};
          entry_count_d = 3'd0;
          if (bus.unlocked) begin
            state_d      = ST_GRANTED;
            grant_cnt_d  = '0;
            fail_count_d = 4'd0;
          end else begin
            fail_event_s = 1'b1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      ST_GRANTED: begin
        fail_count_d = 4'd0;
        if (grant_cnt_q == GRANT_W'(GRANT_CYCLES - 1)) begin
          state_d     = ST_ENTRY;
          grant_cnt_d = '0;
        end else begin
          grant_cnt_d = grant_cnt_q + GRANT_W'(1);
        end
      end

      ST_LOCKOUT: begin
        if (lock_cnt_q == LOCK_W'(LOCKOUT_CYCLES - 1)) begin
          state_d      = ST_ENTRY;
          lock_cnt_d   = '0;
          fail_count_d = 4'd0;
        end else begin
          lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end
      end

      default: begin
        state_d       = ST_ENTRY;
        pin_d         = {4{4'h0}};
        entry_count_d = 3'd0;
      end
    endcase

    // Shared failure handling for short entries and wrong PINs.
    if (fail_event_s) begin
      fail_count_d = fail_next_s;
      if (fail_next_s >= 4'(MAX_FAILS)) begin
        state_d    = ST_LOCKOUT;
        lock_cnt_d = '0;
      end else begin
        state_d = ST_ENTRY;
      end
    end else begin
      fail_count_d = fail_count_d;
    end

`ifdef PIN_ENTRY_TIMEOUT_EN
    // Idle timer only runs on a partial entry; any key restarts it.
    idle_cnt_d = '0;
    if ((state_q == ST_ENTRY) && (entry_count_q != 3'd0) && !bus.key_valid) begin
      if (idle_cnt_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
        pin_d         = {4{4'h0}};
        entry_count_d = 3'd0;
        idle_cnt_d    = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
      end
    end else begin
      idle_cnt_d = '0;
    end
`endif

    // Outputs are registered from the next state so they line up with it.
    access_granted_d = (state_d == ST_GRANTED);
    locked_out_d     = (state_d == ST_LOCKOUT);
    access_denied_d  = fail_event_s;
    if (state_d == ST_CHECK) begin
      digit_d = pin_d;
    end else begin
      // 0xF never appears in a valid code, so no match is possible.
      digit_d = {4{4'hF}};
    end
  end

  // State, buffer, counters and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_ENTRY;
      pin_q            <= {4{4'h0}};
      entry_count_q    <= 3'd0;
      wait_cnt_q       <= '0;
      grant_cnt_q      <= '0;
      lock_cnt_q       <= '0;
      fail_count_q     <= 4'd0;
      access_granted_q <= 1'b0;
      access_denied_q  <= 1'b0;
      locked_out_q     <= 1'b0;
      digit_q          <= {4{4'hF}};
    end else begin
      state_q          <= state_d;
      pin_q            <= pin_d;
      entry_count_q    <= entry_count_d;
      wait_cnt_q       <= wait_cnt_d;
      grant_cnt_q      <= grant_cnt_d;
      lock_cnt_q       <= lock_cnt_d;
      fail_count_q     <= fail_count_d;
      access_granted_q <= access_granted_d;
      access_denied_q  <= access_denied_d;
      locked_out_q     <= locked_out_d;
      digit_q          <= digit_d;
    end
  end

`ifdef PIN_ENTRY_TIMEOUT_EN
  // Idle counter register for the partial-entry timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  // Partial entries are held indefinitely; no idle counter exists.
`endif

  assign bus.digit1         = digit_q[0];
  assign bus.digit2         = digit_q[1];
  assign bus.digit3         = digit_q[2];
  assign bus.digit4         = digit_q[3];
  assign bus.entry_count    = entry_count_q;
  assign bus.access_granted = access_granted_q;
  assign bus.access_denied  = access_denied_q;
  assign bus.locked_out     = locked_out_q;
  assign bus.fail_count     = fail_count_q;

endmodule

// File: tb/tb_pin_entry_sequencer.sv
// Directed bench for pin_entry_sequencer with a registered comparator model
// whose set code is 1,2,3,4.
module tb_pin_entry_sequencer;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  int   g_cnt, d_cnt, l_cnt, pin_cnt, both_cnt;

  pin_entry_sequencer_if bus ();

  pin_entry_sequencer #(
    .RESULT_LATENCY (1),
    .GRANT_CYCLES   (4),
    .MAX_FAILS      (3),
    .LOCKOUT_CYCLES (8),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator model: one registered cycle, set code 1,2,3,4.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.unlocked <= 1'b0;
    end else begin
      bus.unlocked <= (bus.digit1 == 4'h1) && (bus.digit2 == 4'h2) &&
                      (bus.digit3 == 4'h3) && (bus.digit4 == 4'h4);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_cnt();
    g_cnt = 0; d_cnt = 0; l_cnt = 0; pin_cnt = 0; both_cnt = 0;
  endtask

  // One clock; sample 1 time unit after the edge and accumulate events.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.access_granted) g_cnt++;
    if (bus.access_denied) d_cnt++;
    if (bus.locked_out) l_cnt++;
    if (bus.access_granted && bus.locked_out) both_cnt++;
    if ({bus.digit1, bus.digit2, bus.digit3, bus.digit4} == 16'h1234) pin_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input logic [3:0] code);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    tick();
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic enter5(input logic [3:0] a, b, c, d);
    press(a); press(b); press(c); press(d); press(4'hB);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    clr_cnt();
    reset = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    ticks(2);
    reset = 1'b0;

    // Reset values.
    chk("rst_digits", {bus.digit1, bus.digit2, bus.digit3, bus.digit4}, 16'hFFFF);
    chk("rst_count", bus.entry_count, 3'd0);
    chk("rst_flags", {bus.access_granted, bus.access_denied, bus.locked_out}, 3'b000);
    chk("rst_fail", bus.fail_count, 4'd0);

    // 1: correct PIN grants for 4 cycles.
    clr_cnt();
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    chk("s1_count4", bus.entry_count, 3'd4);
    chk("s1_dig_hidden", bus.digit1, 4'hF);
    press(4'hB);
    chk("s1_dig_check", {bus.digit1, bus.digit2, bus.digit3, bus.digit4}, 16'h1234);
    ticks(8);
    chk("s1_grant_len", g_cnt, 4);
    chk("s1_check_len", pin_cnt, 2);
    chk("s1_no_deny", d_cnt, 0);
    chk("s1_fail", bus.fail_count, 4'd0);
    chk("s1_dig_after", {bus.digit1, bus.digit2, bus.digit3, bus.digit4}, 16'hFFFF);
    chk("s1_count_after", bus.entry_count, 3'd0);

    // 2: wrong PIN gives one denial.
    clr_cnt();
    enter5(4'h1, 4'h2, 4'h3, 4'h5);
    ticks(6);
    chk("s2_deny", d_cnt, 1);
    chk("s2_grant", g_cnt, 0);
    chk("s2_fail", bus.fail_count, 4'd1);
    chk("s2_count", bus.entry_count, 3'd0);
    chk("s2_locked", bus.locked_out, 1'b0);

    // 3: three wrong entries lock out for 8 cycles.
    do_reset();
    enter5(4'h1, 4'h2, 4'h3, 4'h5);
    ticks(6);
    chk("s3_fail1", bus.fail_count, 4'd1);
    enter5(4'h9, 4'h9, 4'h9, 4'h9);
    ticks(6);
    chk("s3_fail2", bus.fail_count, 4'd2);
    chk("s3_not_locked", bus.locked_out, 1'b0);
    clr_cnt();
    enter5(4'h1, 4'h2, 4'h3, 4'h5);
    ticks(2);
    chk("s3_locked", bus.locked_out, 1'b1);
    chk("s3_fail3", bus.fail_count, 4'd3);
    enter5(4'h1, 4'h2, 4'h3, 4'h4);
    ticks(6);
    chk("s3_lock_len", l_cnt, 8);
    chk("s3_no_grant", g_cnt, 0);
    chk("s3_excl", both_cnt, 0);
    chk("s3_deny", d_cnt, 1);
    chk("s3_fail_exit", bus.fail_count, 4'd0);
    chk("s3_count", bus.entry_count, 3'd0);

    // 4: clear then short entry fails; fifth digit ignored.
    clr_cnt();
    press(4'h1); press(4'h2); press(4'hA);
    chk("s4_cleared", bus.entry_count, 3'd0);
    press(4'h3); press(4'h4); press(4'hB);
    chk("s4_deny_pulse", bus.access_denied, 1'b1);
    ticks(3);
    chk("s4_deny", d_cnt, 1);
    chk("s4_fail", bus.fail_count, 4'd1);
    chk("s4_count", bus.entry_count, 3'd0);
    clr_cnt();
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h9);
    chk("s4_count_full", bus.entry_count, 3'd4);
    press(4'hB);
    ticks(8);
    chk("s4_grant_len", g_cnt, 4);
    chk("s4_pin", pin_cnt, 2);
    chk("s4_fail_clr", bus.fail_count, 4'd0);

    // 5: reset in the 2nd lockout cycle.
    do_reset();
    press(4'hB); press(4'hB);
    chk("s5_fail2", bus.fail_count, 4'd2);
    press(4'hB);
    chk("s5_lock1", bus.locked_out, 1'b1);
    tick();
    chk("s5_lock2", bus.locked_out, 1'b1);
    do_reset();
    chk("s5_locked", bus.locked_out, 1'b0);
    chk("s5_fail", bus.fail_count, 4'd0);
    chk("s5_digits", {bus.digit1, bus.digit2, bus.digit3, bus.digit4}, 16'hFFFF);
    chk("s5_count", bus.entry_count, 3'd0);

    // 6: partial entry idle for 10 cycles.
    do_reset();
    press(4'h1);
    press(4'hC);
    chk("s6_ignored", bus.entry_count, 3'd1);
    ticks(10);
`ifdef PIN_ENTRY_TIMEOUT_EN
    chk("s6_timeout", bus.entry_count, 3'd0);
`else
    chk("s6_held", bus.entry_count, 3'd1);
`endif
    chk("s6_fail", bus.fail_count, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
